// File: rtl/pipe_mips32_pkg.sv
// rtl/pipe_mips32_pkg.sv - opcodes, widths and fetch-state type shared by the pipelined MIPS32 core
package pipe_mips32_pkg;
    localparam int WORD_W = 32;

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_AND   = 6'b000010;
    localparam logic [5:0] OP_OR    = 6'b000011;
    localparam logic [5:0] OP_SLT   = 6'b000100;
    localparam logic [5:0] OP_MUL   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b001000;
    localparam logic [5:0] OP_SW    = 6'b001001;
    localparam logic [5:0] OP_ADDI  = 6'b001010;
    localparam logic [5:0] OP_SUBI  = 6'b001011;
    localparam logic [5:0] OP_SLTI  = 6'b001100;
    localparam logic [5:0] OP_BNEQZ = 6'b001101;
    localparam logic [5:0] OP_BEQZ  = 6'b001110;
    localparam logic [5:0] OP_HLT   = 6'b111111;

    typedef enum logic [2:0] {
        IT_RR_ALU, IT_RM_ALU, IT_LOAD, IT_STORE, IT_BRANCH, IT_HALT
    } instr_type_e;

    typedef enum logic {ST_FETCH, ST_STOPPED} fetch_state_e;

    function automatic logic is_hlt(input logic [WORD_W-1:0] ir);
        return ir[31:26] == OP_HLT;
    endfunction
endpackage

// File: rtl/if_fifo.sv
// rtl/if_fifo.sv - synchronous FIFO holding fetched {ir, npc} entries, with flush
module if_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 64,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic [W-1:0]  i_data,
    input  logic          i_pop,
    input  logic          i_flush,
    output logic [W-1:0]  o_data,
    output logic          o_empty,
    output logic          o_full,
    output logic [CW-1:0] o_count
);
    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_count = r_count;
endmodule

// File: rtl/if_prefetch_unit.sv
// rtl/if_prefetch_unit.sv - credit-based instruction prefetch with redirect/flush and HLT stop
// Define IF_RSP_BYPASS_EN to forward a response straight to decode when the FIFO is empty.
module if_prefetch_unit
    import pipe_mips32_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter int          AW       = 10,
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic          clk1,
    input  logic          rst_n,
    input  logic          redirect_valid,
    input  logic [31:0]   redirect_pc,
    output logic          imem_req_valid,
    input  logic          imem_req_ready,
    output logic [AW-1:0] imem_req_addr,
    input  logic          imem_rsp_valid,
    input  logic [31:0]   imem_rsp_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_ir,
    output logic [31:0]   out_npc,
    output logic          fetch_stopped
);
    localparam int CW = $clog2(DEPTH + 1);

    fetch_state_e  r_state;
    logic [31:0]   r_pc;
    logic [31:0]   r_rsp_pc;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_drop;

    logic          w_req_fire, w_rsp_take, w_bypass, w_push, w_pop;
    logic          w_empty, w_full;
    logic [CW-1:0] w_count;
    logic [63:0]   w_head;
    logic [31:0]   w_rsp_npc;
    logic [CW:0]   w_credit;

    // Occupancy plus in-flight requests never exceeds DEPTH, so every response has a slot.
    assign w_credit       = {1'b0, w_count} + {1'b0, r_outstanding};
    assign imem_req_valid = rst_n && (r_state == ST_FETCH) && !redirect_valid
                            && (w_credit < (CW+1)'(DEPTH));
    assign imem_req_addr  = r_pc[AW-1:0];
    assign w_req_fire     = imem_req_valid && imem_req_ready;
    assign w_rsp_take     = imem_rsp_valid && (r_drop == '0) && !redirect_valid;
    assign w_rsp_npc      = r_rsp_pc + 32'd1;

`ifdef IF_RSP_BYPASS_EN
    assign w_bypass = w_rsp_take && w_empty;
`else
    assign w_bypass = 1'b0;
`endif

    assign out_valid = !w_empty || w_bypass;
    assign out_ir    = !w_empty ? w_head[63:32] : (w_bypass ? imem_rsp_data : 32'd0);
    assign out_npc   = !w_empty ? w_head[31:0]  : (w_bypass ? w_rsp_npc     : 32'd0);
    assign w_pop     = !w_empty && out_ready;
    assign w_push    = w_rsp_take && !(w_bypass && out_ready) && (!w_full || w_pop);
    assign fetch_stopped = (r_state == ST_STOPPED);

    if_fifo #(.DEPTH(DEPTH), .W(64)) u_fifo (
        .clk     (clk1),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  ({imem_rsp_data, w_rsp_npc}),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .o_data  (w_head),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_count (w_count)
    );

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_FETCH;
            r_pc          <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_outstanding <= '0;
            r_drop        <= '0;
        end else begin
            if (redirect_valid) begin
                // A response landing in the redirect cycle is stale and already discarded.
                r_state  <= ST_FETCH;
                r_pc     <= redirect_pc;
                r_rsp_pc <= redirect_pc;
                r_drop   <= imem_rsp_valid ? r_outstanding - 1'b1 : r_outstanding;
            end else begin
                if (w_req_fire) r_pc <= r_pc + 32'd1;
                if (imem_rsp_valid) begin
                    if (r_drop != '0) begin
                        r_drop <= r_drop - 1'b1;
                    end else begin
                        r_rsp_pc <= w_rsp_npc;
                        if (is_hlt(imem_rsp_data)) r_state <= ST_STOPPED;
                    end
                end
            end
            case ({w_req_fire, imem_rsp_valid})
                2'b10:   r_outstanding <= r_outstanding + 1'b1;
                2'b01:   r_outstanding <= r_outstanding - 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_if_prefetch_unit.sv
// tb/tb_if_prefetch_unit.sv - directed self-checking bench for if_prefetch_unit
module tb_if_prefetch_unit;
    import pipe_mips32_pkg::*;

    localparam int DEPTH = 4;
    localparam int AW    = 10;

    logic          clk1 = 1'b0;
    logic          rst_n;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic          imem_req_valid;
    logic          imem_req_ready;
    logic [AW-1:0] imem_req_addr;
    logic          imem_rsp_valid;
    logic [31:0]   imem_rsp_data;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_ir;
    logic [31:0]   out_npc;
    logic          fetch_stopped;

    always #5 clk1 = ~clk1;

    if_prefetch_unit #(.DEPTH(DEPTH), .AW(AW), .RESET_PC(32'd0)) dut (
        .clk1           (clk1),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_ir         (out_ir),
        .out_npc        (out_npc),
        .fetch_stopped  (fetch_stopped)
    );

    typedef struct {logic [31:0] data; int due;} pend_t;
    typedef struct {logic [31:0] ir; logic [31:0] npc; int cyc;} out_t;

    logic [31:0] mem [0:1023];
    pend_t       pend_q[$];
    out_t        got[$];
    logic [31:0] req_q[$];
    int          cyc = 0;
    int          lat = 1;
    int          n_tests = 0;
    int          n_fail = 0;
    logic        mem_rsp_on = 1'b0;

    assign imem_rsp_valid = mem_rsp_on && rst_n;

    // Memory model with fixed latency, plus a monitor of requests and delivered instructions.
    always @(posedge clk1) begin
        if (!rst_n) begin
            pend_q.delete();
        end else begin
            if (imem_rsp_valid) void'(pend_q.pop_front());
            if (imem_req_valid && imem_req_ready) begin
                pend_q.push_back('{mem[imem_req_addr], cyc + lat});
                req_q.push_back(32'(imem_req_addr));
            end
            if (out_valid && out_ready) got.push_back('{out_ir, out_npc, cyc});
        end
        cyc++;
    end

    always @(negedge clk1) begin
        mem_rsp_on    = (pend_q.size() > 0) && (pend_q[0].due == cyc);
        imem_rsp_data = (pend_q.size() > 0) ? pend_q[0].data : 32'd0;
    end

    function automatic logic [31:0] mk(input logic [5:0] op, input int i);
        return {op, 26'(i)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk1);
    endtask

    task automatic do_reset(input int l);
        @(negedge clk1);
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        lat            = l;
        repeat (2) @(negedge clk1);
        req_q.delete();
        got.delete();
        rst_n = 1'b1;
    endtask

    task automatic pulse_redirect(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        @(negedge clk1);
        redirect_valid = 1'b0;
    endtask

    initial begin
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        out_ready      = 1'b0;
        imem_req_ready = 1'b1;
        for (int i = 0; i < 1024; i++) mem[i] = mk(OP_ADD, i);
        mem[1] = mk(OP_SUB, 1);
        mem[2] = mk(OP_OR, 2);
        mem[3] = mk(OP_AND, 3);

        // Reset state
        cycles(2);
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_ir", out_ir, 32'd0);
        chk("rst_out_npc", out_npc, 32'd0);
        chk("rst_stopped", 32'(fetch_stopped), 32'd0);

        // 1: streaming, L=1
        out_ready = 1'b1;
        do_reset(1);
        cycles(10);
        for (int i = 0; i < 4; i++) begin
            chk("t1_ir", got[i].ir, mem[i]);
            chk("t1_npc", got[i].npc, 32'(i + 1));
            chk("t1_addr", req_q[i], 32'(i));
        end
        chk("t1_rate", 32'(got[3].cyc - got[0].cyc), 32'd3);

        // 2: backpressure fills exactly DEPTH entries
        out_ready = 1'b0;
        do_reset(1);
        cycles(10);
        chk("t2_nreq", 32'(req_q.size()), 32'd4);
        chk("t2_req_valid", 32'(imem_req_valid), 32'd0);
        chk("t2_hold_valid", 32'(out_valid), 32'd1);
        chk("t2_hold_ir", out_ir, mem[0]);
        chk("t2_hold_npc", out_npc, 32'd1);
        out_ready = 1'b1;
        cycles(10);
        for (int i = 0; i < 4; i++) begin
            chk("t2_ir", got[i].ir, mem[i]);
            chk("t2_npc", got[i].npc, 32'(i + 1));
        end
        chk("t2_resume_addr", req_q[4], 32'd4);

        // 3: redirect with two outstanding, L=3
        out_ready = 1'b1;
        do_reset(3);
        cycles(2);
        chk("t3_nreq_before", 32'(req_q.size()), 32'd2);
        pulse_redirect(32'd20);
        chk("t3_flushed", 32'(out_valid), 32'd0);
        cycles(10);
        chk("t3_addr", req_q[2], 32'd20);
        chk("t3_first_ir", got[0].ir, mem[20]);
        chk("t3_first_npc", got[0].npc, 32'd21);

        // 4: HLT at address 5, then redirect to 8
        mem[5]    = mk(OP_HLT, 5);
        out_ready = 1'b1;
        do_reset(1);
        cycles(15);
        chk("t4_stopped", 32'(fetch_stopped), 32'd1);
        chk("t4_req_valid", 32'(imem_req_valid), 32'd0);
        chk("t4_nreq", 32'(req_q.size()), 32'd7);
        chk("t4_nout", 32'(got.size()), 32'd7);
        chk("t4_first_npc", got[0].npc, 32'd1);
        chk("t4_hlt_ir", got[5].ir, mk(OP_HLT, 5));
        chk("t4_hlt_npc", got[5].npc, 32'd6);
        req_q.delete();
        got.delete();
        pulse_redirect(32'd8);
        chk("t4_unstopped", 32'(fetch_stopped), 32'd0);
        cycles(6);
        chk("t4_restart_addr", req_q[0], 32'd8);
        chk("t4_restart_ir", got[0].ir, mem[8]);
        chk("t4_restart_npc", got[0].npc, 32'd9);
        mem[5] = mk(OP_ADD, 5);

        // 5: redirect coincident with a response and an output handshake, L=2
        out_ready = 1'b1;
        do_reset(2);
        cycles(4);
        chk("t5_pre_valid", 32'(out_valid), 32'd1);
        chk("t5_pre_ir", out_ir, mem[1]);
        pulse_redirect(32'd40);
        cycles(10);
        chk("t5_out0_npc", got[0].npc, 32'd1);
        chk("t5_out1_npc", got[1].npc, 32'd2);
        chk("t5_out1_ir", got[1].ir, mem[1]);
        chk("t5_out2_npc", got[2].npc, 32'd41);
        chk("t5_out2_ir", got[2].ir, mem[40]);
        chk("t5_redirect_addr", req_q[4], 32'd40);

        // 6: reset mid-stream with three outstanding, L=3
        out_ready = 1'b0;
        do_reset(3);
        cycles(4);
        chk("t6_pre_valid", 32'(out_valid), 32'd1);
        chk("t6_pre_ir", out_ir, mem[0]);
        rst_n = 1'b0;
        #1;
        chk("t6_req_valid", 32'(imem_req_valid), 32'd0);
        chk("t6_out_valid", 32'(out_valid), 32'd0);
        chk("t6_out_ir", out_ir, 32'd0);
        chk("t6_out_npc", out_npc, 32'd0);
        chk("t6_stopped", 32'(fetch_stopped), 32'd0);
        repeat (2) @(negedge clk1);
        req_q.delete();
        got.delete();
        out_ready = 1'b1;
        rst_n     = 1'b1;
        cycles(8);
        chk("t6_first_addr", req_q[0], 32'd0);
        chk("t6_first_ir", got[0].ir, mem[0]);
        chk("t6_first_npc", got[0].npc, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
